// File: rtl/serial_key_schedule.sv
// serial_key_schedule
//
// Serial round-key generator for the theta stage. A master key is split into
// N = KEY_SIZE/SIDE_SIZE words W0..W(N-1). The current round key is W0,
// offered with a valid/ready handshake. Each accepted key advances the word
// state by one step (word shift plus a rotate/XOR feedback word). After ROUNDS
// keys the block parks in DONE until a new key is loaded.
//
// Parameters:
//   KEY_SIZE  master key width (multiple of SIDE_SIZE, >= 2*SIDE_SIZE)
//   SIDE_SIZE round-key width (>= 6, so round_idx fits in the feedback word)
//   ROUNDS    round keys per key load (1..64)
//   PK        left-rotate amount applied to W0 in the feedback word
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears control and key words)
//   key_load   capture key_in (honoured in IDLE and DONE only)
//   key_in     master key; the most significant word becomes W0
//   start      begin issuing round keys (honoured in LOADED only)
//   rk         current round key (W0)
//   rk_valid   rk carries a valid key (high in RUN only)
//   rk_ready   consumer accepts rk this cycle
//   round_idx  index of the key currently on rk
//   busy       high in RUN
//   done       high in DONE
//
// Build option:
//   SWAN_KEY_ZEROIZE_EN  when defined, all key words are cleared on the edge
//                        that enters DONE, so no key material is retained.

module serial_key_schedule #(
  parameter int KEY_SIZE  = 256,
  parameter int SIDE_SIZE = 64,
  parameter int ROUNDS    = 48,
  parameter int PK        = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_load,
  input  logic [KEY_SIZE-1:0]  key_in,
  input  logic                 start,
  output logic [SIDE_SIZE-1:0] rk,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [5:0]           round_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int         N        = KEY_SIZE / SIDE_SIZE;
  localparam int         PK_MOD   = PK % SIDE_SIZE;
  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SIDE_SIZE-1:0] w [N];
  logic [SIDE_SIZE-1:0] w_new;
  logic                 xfer;
  logic                 last_xfer;
  logic                 load_ok;

  // Rotate left by PK; PK_MOD = 0 degenerates to identity because the
  // right shift by SIDE_SIZE yields zero.
  function automatic logic [SIDE_SIZE-1:0] rotl_pk(input logic [SIDE_SIZE-1:0] x);
    return (x << PK_MOD) | (x >> (SIDE_SIZE - PK_MOD));
  endfunction

  // Round index injected into the low 6 bits of the feedback word.
  function automatic logic [SIDE_SIZE-1:0] idx_word(input logic [5:0] idx);
    return {{(SIDE_SIZE-6){1'b0}}, idx};
  endfunction

  always_comb begin
    xfer      = (state == RUN) && rk_ready;
    last_xfer = xfer && (round_idx == LAST_IDX);
    load_ok   = key_load && ((state == IDLE) || (state == DONE));
    w_new     = rotl_pk(w[0]) ^ w[1] ^ idx_word(round_idx);
  end

  // Next-state logic; start wins over key_load in LOADED simply because
  // key_load has no transition out of LOADED.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_load)  state_nxt = LOADED;
      LOADED:  if (start)     state_nxt = RUN;
      RUN:     if (last_xfer) state_nxt = DONE;
      DONE:    if (key_load)  state_nxt = LOADED;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The final transfer leaves round_idx at ROUNDS-1 so it never wraps,
  // even with ROUNDS = 64.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_idx <= '0;
    end else if (load_ok) begin
      round_idx <= '0;
    end else if (xfer && !last_xfer) begin
      round_idx <= round_idx + 6'd1;
    end
  end

  // Key word state: load, advance one step per accepted key, and freeze
  // (or zeroize) on the last accepted key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        w[i] <= '0;
      end
    end else if (load_ok) begin
      for (int i = 0; i < N; i++) begin
        w[i] <= key_in[KEY_SIZE-1-i*SIDE_SIZE -: SIDE_SIZE];
      end
    end else if (xfer && !last_xfer) begin
      for (int i = 0; i < N-1; i++) begin
        w[i] <= w[i+1];
      end
      w[N-1] <= w_new;
`ifdef SWAN_KEY_ZEROIZE_EN
    end else if (last_xfer) begin
      for (int i = 0; i < N; i++) begin
        w[i] <= '0;
      end
`else
`endif
    end
  end

  always_comb begin
    rk       = w[0];
    rk_valid = (state == RUN);
    busy     = (state == RUN);
    done     = (state == DONE);
  end

endmodule
